// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store unit.
//   size_e  : request size codes (byte, half, word, reserved).
//   state_e : load_store_unit controller states.
//   is_misaligned / align_off : low-address-bit rules for sub-word and word accesses.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StWr,
      StResp
   } state_e;

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

   // Clear the low address bits a given access size is not allowed to use.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] res;
      case (size)
         SZ_HALF: res = {off[1], 1'b0};
         SZ_WORD: res = 2'b00;
         default: res = off;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for the load/store unit.
// Ports:
//   size       in  access size (lsu_pkg::size_e)
//   sign_ext   in  sign-extend the extracted lane on loads
//   off        in  byte offset in the word (already aligned for the access size)
//   word       in  word read from RAM
//   wdata      in  right-aligned store data
//   load_data  out extracted and extended load value
//   store_word out word with the store lane(s) merged into 'word'
// Lanes are little-endian: byte lane = off, half lane = off[1].
module lsu_lane_align
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic        sign_ext,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = word[{off, 3'b000} +: 8];
   assign half_lane = word[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_data  = '0;
      store_word = word;
      unique case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            store_word[{off, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SZ_WORD: begin
            load_data  = word;
            store_word = wdata;
         end
         default: begin
            load_data  = '0;
            store_word = word;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-wide RAM without
// byte enables. Sub-word stores are done as read-modify-write. All outputs registered,
// one request outstanding at a time.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_size, req_signed       store flag, size code, sign-extend loads
//   req_addr, req_wdata                byte address, right-aligned store data
//   resp_valid/resp_ready              response handshake
//   resp_rdata, resp_err               extended load data (0 for stores), error flag
//   ram_addr, ram_wdata, ram_we        RAM word address, write data, write enable
//   ram_rdata                          RAM read data, valid one clock after ram_addr
// Build option: define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as
// errors; otherwise offending low address bits are silently cleared.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              sign_q, sign_d;
   logic [1:0]        off_q, off_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;

   logic [1:0]        req_off;
   logic              req_err;
   logic              req_hs;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] store_word;

`ifdef LSU_ALIGN_CHECK_EN
   assign req_off = req_addr[1:0];
   assign req_err = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
   assign req_off = align_off(req_size, req_addr[1:0]);
   assign req_err = (req_size == SZ_RSVD);
`endif

   assign req_hs = req_valid & req_ready_q;

   lsu_lane_align u_lane_align (
      .size       (size_q),
      .sign_ext   (sign_q),
      .off        (off_q),
      .word       (ram_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      sign_d       = sign_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready_d = 1'b1;
            if (req_hs) begin
               req_ready_d = 1'b0;
               we_d        = req_we;
               size_d      = size_e'(req_size);
               sign_d      = req_signed;
               off_d       = req_off;
               wdata_d     = req_wdata;
               if (req_err) begin
                  // No RAM access at all: ram_addr is left untouched.
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  ram_addr_d = {2'b00, req_addr[ADDR_W-1:2]};
                  if (req_we && (req_size == SZ_WORD)) begin
                     state_d     = StWr;
                     ram_we_d    = 1'b1;
                     ram_wdata_d = req_wdata;
                  end else begin
                     state_d = StRd;
                  end
               end
            end
         end
         StRd: begin
            state_d = StRdWait;
         end
         StRdWait: begin
            // ram_rdata for ram_addr is valid in this cycle.
            if (we_q) begin
               state_d     = StWr;
               ram_we_d    = 1'b1;
               ram_wdata_d = store_word;
            end else begin
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = load_data;
            end
         end
         StWr: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
         StResp: begin
            if (resp_ready) begin
               state_d      = StIdle;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         sign_q       <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sign_q       <= sign_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_we     = ram_we_q;

endmodule
